adc_serial_reader: RTL and testbench

Front-end stage for the light-sensing path. The block periodically drives an ADC0831-style 8-bit serial ADC through CS_n, SCLK and DOUT. It then presents each finished conversion as a parallel 8-bit `adc_data` word with a one-cycle `sig` strobe. It feeds the light-intensity comparator/counter stage directly; that stage qualifies `adc_data` only when `sig` is 1.

---
 rtl/adc_pkg.sv | 19 +
 rtl/adc_serial_reader_if.sv | 11 +
 rtl/adc_serial_reader_sample_tick.sv | 46 ++++
 rtl/adc_serial_reader.sv | 143 ++++++++++++++
 tb/tb_adc_serial_reader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC0831-style serial reader.
package adc_pkg;

  localparam int unsigned ADC_BITS              = 8;
  localparam int unsigned NULL_BITS             = 1;
  localparam int unsigned DIV_DEFAULT           = 25;
  localparam int unsigned SAMPLE_CYCLES_DEFAULT = 50000;

  // Index of the final SCLK period (null bit + data bits - 1).
  localparam logic [3:0] LAST_BIT = 4'(ADC_BITS + NULL_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    CLOCK,
    DONE
  } adc_state_e;

endpackage

// File: rtl/adc_serial_reader_if.sv
// Three-wire serial bus between the reader (master) and the ADC (slave).
interface adc_serial_reader_if;

  logic adc_cs_n;
  logic adc_sclk;
  logic adc_dout;

  modport master (output adc_cs_n, output adc_sclk, input adc_dout);
  modport slave  (input adc_cs_n, input adc_sclk, output adc_dout);

endinterface

// File: rtl/adc_serial_reader_sample_tick.sv
// Period counter: one-cycle tick every PERIOD clocks while en is high.
module sample_tick
  import adc_pkg::*;
#(
  parameter int unsigned PERIOD = SAMPLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  // Count 0..PERIOD-1 while enabled, hold at 0 otherwise; tick on wrap.
  always_comb begin
    count_d = '0;
    tick_d  = 1'b0;
    if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/adc_serial_reader.sv
// Periodically reads an ADC0831-style serial ADC and presents each result
// as a parallel word with a one-cycle sig strobe.
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int unsigned DIV           = DIV_DEFAULT,
  parameter int unsigned SAMPLE_CYCLES = SAMPLE_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  adc_serial_reader_if.master        adc,
  output logic [ADC_BITS-1:0]        adc_data,
  output logic                       sig,
  output logic                       overrun
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic tick;

  sample_tick #(.PERIOD(SAMPLE_CYCLES)) u_sample_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  logic [1:0] sync_q, sync_d;
  logic       dout_s;

  // Two-stage synchroniser for the asynchronous ADC data line.
  always_comb sync_d = {sync_q[0], adc.adc_dout};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign dout_s = sync_q[1];

  adc_state_e          state_q,   state_d;
  logic [7:0]          cnt_q,     cnt_d;
  logic [3:0]          bit_q,     bit_d;
  logic [ADC_BITS-1:0] shift_q,   shift_d;
  logic [ADC_BITS-1:0] data_q,    data_d;
  logic                cs_n_q,    cs_n_d;
  logic                sclk_q,    sclk_d;
  logic                sig_q,     sig_d;
  logic                overrun_q, overrun_d;

  // Conversion FSM next-state; outputs are computed one cycle ahead so that
  // every pin comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sig_d     = 1'b0;
    overrun_d = overrun_q;

    if (tick && (state_q != IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = CLOCK;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLOCK: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            // End of high phase: sample; period 0 is the null bit.
            sclk_d = 1'b0;
            if (bit_q != 4'd0) shift_d = {shift_q[ADC_BITS-2:0], dout_s};
          end else if (bit_q == LAST_BIT) begin
            state_d = DONE;
            cs_n_d  = 1'b1;
            data_d  = shift_q;
            sig_d   = 1'b1;
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sig_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      sig_q     <= sig_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc.adc_cs_n = cs_n_q;
  assign adc.adc_sclk = sclk_q;
  assign adc_data     = data_q;
  assign sig          = sig_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed testbench for adc_serial_reader with a behavioural ADC0831 model.
module tb_adc_serial_reader;

  localparam int unsigned DIV    = 4;
  localparam int unsigned SC     = 200;
  localparam int unsigned SC_OVR = 50;
  localparam int          CS_LOW = 19 * DIV;   // cs_n low from tick+1 to tick+19*DIV

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, rst2, en2;
  logic [7:0] adc_data, adc_data2;
  logic       sig, sig2, overrun, overrun2;

  adc_serial_reader_if bus ();
  adc_serial_reader_if bus2 ();

  adc_serial_reader #(.DIV(DIV), .SAMPLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .en(en), .adc(bus.master),
    .adc_data(adc_data), .sig(sig), .overrun(overrun)
  );

  adc_serial_reader #(.DIV(DIV), .SAMPLE_CYCLES(SC_OVR)) dut_ovr (
    .clk(clk), .rst(rst2), .en(en2), .adc(bus2.master),
    .adc_data(adc_data2), .sig(sig2), .overrun(overrun2)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: null bit while cs_n is high, next data bit (MSB first)
  // after each SCLK falling edge.
  logic [7:0]  model_word  = 8'h00;
  logic        model_null  = 1'b0;
  logic        sclk_prev   = 1'b0;
  int unsigned bit_idx     = 0;
  logic [7:0]  model_word2 = 8'h00;
  logic        sclk_prev2  = 1'b0;
  int unsigned bit_idx2    = 0;

  always @(posedge clk) begin
    sclk_prev <= bus.adc_sclk;
    if (bus.adc_cs_n === 1'b1) begin
      bit_idx      <= 0;
      bus.adc_dout <= model_null;
    end else if (sclk_prev && !bus.adc_sclk) begin
      if (bit_idx < 8) bus.adc_dout <= model_word[3'(7 - bit_idx)];
      bit_idx <= bit_idx + 1;
    end
  end

  always @(posedge clk) begin
    sclk_prev2 <= bus2.adc_sclk;
    if (bus2.adc_cs_n === 1'b1) begin
      bit_idx2      <= 0;
      bus2.adc_dout <= 1'b0;
    end else if (sclk_prev2 && !bus2.adc_sclk) begin
      if (bit_idx2 < 8) bus2.adc_dout <= model_word2[3'(7 - bit_idx2)];
      bit_idx2 <= bit_idx2 + 1;
    end
  end

  task automatic wait_cs_low(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.adc_cs_n === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_sig(input bit which, input int limit, output bit ok, output int waited);
    ok     = 1'b0;
    waited = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((which ? sig2 : sig) === 1'b1) begin
        ok     = 1'b1;
        waited = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.adc_cs_n !== 1'b1) begin tests_failed++; $display("FAIL reset_cs_n got %b want 1", bus.adc_cs_n); end
    tests_run++;
    if (bus.adc_sclk !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk got %b want 0", bus.adc_sclk); end
    tests_run++;
    if (adc_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", adc_data); end
    tests_run++;
    if (sig !== 1'b0) begin tests_failed++; $display("FAIL reset_sig got %b want 0", sig); end
    tests_run++;
    if (overrun !== 1'b0 || overrun2 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overrun got %b/%b want 0/0", overrun, overrun2);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    bit ok;
    int n_low, rises, first_rise;
    logic prev;
    model_word = 8'hA5;
    model_null = 1'b0;
    en = 1'b1;
    wait_cs_low(SC + 50, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL nominal_start got no cs_n fall want fall"); return; end
    n_low = 1; rises = 0; first_rise = -1; prev = bus.adc_sclk;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.adc_cs_n !== 1'b0) break;
      n_low++;
      if (bus.adc_sclk && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = i;
      end
      prev = bus.adc_sclk;
    end
    tests_run++;
    if (n_low != CS_LOW) begin tests_failed++; $display("FAIL nominal_cs_low got %0d want %0d", n_low, CS_LOW); end
    tests_run++;
    if (first_rise != DIV) begin tests_failed++; $display("FAIL nominal_first_sclk got %0d want %0d", first_rise, DIV); end
    tests_run++;
    if (rises != 9) begin tests_failed++; $display("FAIL nominal_sclk_rises got %0d want 9", rises); end
    tests_run++;
    if (sig !== 1'b1) begin tests_failed++; $display("FAIL nominal_sig got %b want 1", sig); end
    tests_run++;
    if (adc_data !== 8'hA5) begin tests_failed++; $display("FAIL nominal_data got %h want a5", adc_data); end
    model_word = 8'h0F;
    @(negedge clk);
    tests_run++;
    if (sig !== 1'b0) begin tests_failed++; $display("FAIL nominal_sig_width got %b want 0", sig); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    bit ok;
    int waited, last_cyc;
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h50;
    last_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      wait_sig(1'b0, SC + 100, ok, waited);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL b2b_sig%0d got timeout want pulse", k); return; end
      tests_run++;
      if (adc_data !== words[k]) begin tests_failed++; $display("FAIL b2b_data%0d got %h want %h", k, adc_data, words[k]); end
      if (last_cyc >= 0) begin
        tests_run++;
        if (cyc - last_cyc != SC) begin
          tests_failed++; $display("FAIL b2b_period%0d got %0d want %0d", k, cyc - last_cyc, SC);
        end
      end
      last_cyc = cyc;
      if (k < 2) model_word = words[k + 1];
      else       model_word = 8'h96;
      repeat (100) @(negedge clk);
      tests_run++;
      if (adc_data !== words[k]) begin tests_failed++; $display("FAIL b2b_hold%0d got %h want %h", k, adc_data, words[k]); end
    end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int rises, waited;
    logic prev;
    wait_cs_low(SC + 50, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rstmid_start got no cs_n fall want fall"); return; end
    rises = 0; prev = bus.adc_sclk;
    for (int i = 0; i < 200 && rises < 6; i++) begin
      @(negedge clk);
      if (bus.adc_sclk && !prev) rises++;
      prev = bus.adc_sclk;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.adc_cs_n !== 1'b1 || bus.adc_sclk !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_pins got cs_n=%b sclk=%b want 1/0", bus.adc_cs_n, bus.adc_sclk);
    end
    tests_run++;
    if (adc_data !== 8'h00 || sig !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_out got data=%h sig=%b want 00/0", adc_data, sig);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_sig(1'b0, SC + 200, ok, waited);
    tests_run++;
    if (!ok || adc_data !== 8'h96) begin
      tests_failed++; $display("FAIL rstmid_next got ok=%0d data=%h want 1/96", ok, adc_data);
    end
  endtask

  task automatic test_null_discard;
    bit ok;
    int waited;
    model_null = 1'b1;
    model_word = 8'h00;
    wait_sig(1'b0, SC + 100, ok, waited);
    tests_run++;
    if (!ok || adc_data !== 8'h00) begin
      tests_failed++; $display("FAIL null_discard got ok=%0d data=%h want 1/00", ok, adc_data);
    end
    model_null = 1'b0;
  endtask

  task automatic test_en_drop;
    bit ok;
    int waited, cs_act, sig_act;
    model_word = 8'h3A;
    wait_cs_low(SC + 50, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL endrop_start got no cs_n fall want fall"); return; end
    repeat (29) @(negedge clk);
    en = 1'b0;
    wait_sig(1'b0, 100, ok, waited);
    tests_run++;
    if (!ok || waited != 47) begin
      tests_failed++; $display("FAIL endrop_sig_time got ok=%0d after=%0d want 1/47", ok, waited);
    end
    tests_run++;
    if (adc_data !== 8'h3A) begin tests_failed++; $display("FAIL endrop_data got %h want 3a", adc_data); end
    cs_act = 0; sig_act = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.adc_cs_n !== 1'b1) cs_act++;
      if (sig !== 1'b0) sig_act++;
    end
    tests_run++;
    if (cs_act != 0) begin tests_failed++; $display("FAIL endrop_idle_cs got %0d active cycles want 0", cs_act); end
    tests_run++;
    if (sig_act != 0) begin tests_failed++; $display("FAIL endrop_idle_sig got %0d pulses want 0", sig_act); end
  endtask

  task automatic test_overrun;
    bit ok;
    int waited, first_cyc;
    model_word2 = 8'h3C;
    rst2 = 1'b0;
    en2  = 1'b1;
    wait_sig(1'b1, 300, ok, waited);
    tests_run++;
    if (!ok || adc_data2 !== 8'h3C) begin
      tests_failed++; $display("FAIL ovr_data0 got ok=%0d data=%h want 1/3c", ok, adc_data2);
    end
    tests_run++;
    if (overrun2 !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b want 1", overrun2); end
    first_cyc = cyc;
    model_word2 = 8'hC3;
    @(negedge clk);
    tests_run++;
    if (sig2 !== 1'b0) begin tests_failed++; $display("FAIL ovr_sig_width got %b want 0", sig2); end
    wait_sig(1'b1, 300, ok, waited);
    tests_run++;
    if (!ok || adc_data2 !== 8'hC3) begin
      tests_failed++; $display("FAIL ovr_data1 got ok=%0d data=%h want 1/c3", ok, adc_data2);
    end
    tests_run++;
    if (cyc - first_cyc != 2 * SC_OVR) begin
      tests_failed++; $display("FAIL ovr_period got %0d want %0d", cyc - first_cyc, 2 * SC_OVR);
    end
    en2 = 1'b0;
    repeat (150) @(negedge clk);
    tests_run++;
    if (overrun2 !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got %b want 1", overrun2); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_reset_mid();
    test_null_discard();
    test_en_drop();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
